traffic_density_estimator: RTL

Upstream feeder for the four-way traffic light controller. Takes raw vehicle-detector pulses from the North, South, East and West approaches and synchronises and debounces them. Counts vehicles per direction over a fixed sampling window, then quantises each count into the 2-bit density code the controller consumes: 00 low, 01 medium, 10 high, 11 very high. Outputs are held stable between window boundaries, so the controller can sample them at any time.

---
 rtl/traffic_density_estimator.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/traffic_density_estimator.sv
// ============================================================================
//  Module   : traffic_density_estimator
//  Brief    : Synchronises and debounces four vehicle-detector inputs, counts
//             vehicles per approach over a fixed window and publishes a 2-bit
//             density code per approach at every window close.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module traffic_density_estimator #(
    parameter int WINDOW   = 256,
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 3,
    parameter int TH_MED   = 4,
    parameter int TH_HIGH  = 8,
    parameter int TH_VHIGH = 12
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       sens_n,
    input  logic       sens_s,
    input  logic       sens_e,
    input  logic       sens_w,
    output logic [1:0] traffic_n,
    output logic [1:0] traffic_s,
    output logic [1:0] traffic_e,
    output logic [1:0] traffic_w,
    output logic       density_valid
);

    // Direction index order: 0 = North, 1 = South, 2 = East, 3 = West
    localparam int c_NDIR   = 4;
    localparam int c_WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_STB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WINDOW - 1);
    localparam logic [c_STB_W-1:0]  c_STB_LAST  = c_STB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    c_TH_MED    = CNT_W'(TH_MED);
    localparam logic [CNT_W-1:0]    c_TH_HIGH   = CNT_W'(TH_HIGH);
    localparam logic [CNT_W-1:0]    c_TH_VHIGH  = CNT_W'(TH_VHIGH);
    localparam logic [1:0]          c_DEFAULT   = 2'b01;

    // Map a vehicle count onto the controller's 2-bit density scale
    function automatic logic [1:0] f_quantise(input logic [CNT_W-1:0] c);
        logic [1:0] code;
        if (c >= c_TH_VHIGH)
            code = 2'b11;
        else if (c >= c_TH_HIGH)
            code = 2'b10;
        else if (c >= c_TH_MED)
            code = 2'b01;
        else
            code = 2'b00;
        return code;
    endfunction

    logic [c_NDIR-1:0]   w_sens;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                w_close;
    logic                r_valid;

    assign w_sens  = {sens_w, sens_e, sens_s, sens_n};
    assign w_close = (r_wcnt == c_WCNT_LAST);

    // Free-running window counter; the last count value marks the close cycle
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a)
            r_wcnt <= '0;
        else if (w_close)
            r_wcnt <= '0;
        else
            r_wcnt <= r_wcnt + 1'b1;
    end

    // One-cycle strobe accompanying each refresh of the density codes
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a)
            r_valid <= 1'b0;
        else
            r_valid <= w_close;
    end

    generate
        for (genvar i = 0; i < c_NDIR; i++) begin : g_dir
            logic [1:0]         r_sync;
            logic               r_acc;
            logic               r_acc_d;
            logic [c_STB_W-1:0] r_stb;
            logic [CNT_W-1:0]   r_cnt;
            logic [1:0]         r_traffic;
            logic               w_event;
            logic [CNT_W-1:0]   w_cnt_next;

            // Two-flop synchroniser for the asynchronous detector level
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a)
                    r_sync <= '0;
                else
                    r_sync <= {r_sync[0], w_sens[i]};
            end

            // Accept a new level only after DEBOUNCE consecutive mismatches
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a) begin
                    r_acc <= 1'b0;
                    r_stb <= '0;
                end else if (r_sync[1] == r_acc) begin
                    r_stb <= '0;
                end else if (r_stb == c_STB_LAST) begin
                    r_acc <= r_sync[1];
                    r_stb <= '0;
                end else begin
                    r_stb <= r_stb + 1'b1;
                end
            end

            // Delayed accepted level for rising-edge (vehicle arrival) detection
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a)
                    r_acc_d <= 1'b0;
                else
                    r_acc_d <= r_acc;
            end

            assign w_event    = r_acc & ~r_acc_d;
            // Saturating increment; an arrival in the close cycle still
            // belongs to the window being closed
            assign w_cnt_next = (w_event && (r_cnt != c_CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;

            // Per-approach vehicle count, cleared at every window close
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a)
                    r_cnt <= '0;
                else if (w_close)
                    r_cnt <= '0;
                else
                    r_cnt <= w_cnt_next;
            end

            // Density code is refreshed only at the close and held otherwise
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a)
                    r_traffic <= c_DEFAULT;
                else if (w_close)
                    r_traffic <= f_quantise(w_cnt_next);
            end
        end
    endgenerate

    assign traffic_n     = g_dir[0].r_traffic;
    assign traffic_s     = g_dir[1].r_traffic;
    assign traffic_e     = g_dir[2].r_traffic;
    assign traffic_w     = g_dir[3].r_traffic;
    assign density_valid = r_valid;

endmodule

`default_nettype wire
